// File: rtl/flt2fix_seq_conv_if.sv
// Stream bundle for flt2fix_seq_conv: float operand in, signed fixed-point result and flags out.
interface flt2fix_seq_conv_if #(
   parameter int EW = 8,
   parameter int MW = 23,
   parameter int FW = 32
);
   logic            inValid;
   logic            inReady;
   logic [EW+MW:0]  floatIn;
   logic            outValid;
   logic            outReady;
   logic [FW-1:0]   fixedOut;
   logic            ovf;
   logic            udf;
   logic            inv;

   modport master (
      output inValid, floatIn, outReady,
      input  inReady, outValid, fixedOut, ovf, udf, inv
   );

   modport slave (
      input  inValid, floatIn, outReady,
      output inReady, outValid, fixedOut, ovf, udf, inv
   );
endinterface

// File: rtl/flt2fix_seq_conv.sv
// Iterative float-to-signed-fixed converter: one alignment shift per cycle, then round, sign and saturate.
// Define FLT2FIX_ROUND_EN for round-to-nearest-even; otherwise the magnitude is truncated toward zero.
module flt2fix_seq_conv #(
   parameter int EW   = 8,
   parameter int MW   = 23,
   parameter int FW   = 32,
   parameter int FRAC = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   flt2fix_seq_conv_if.slave  bus
);
   localparam int DW   = EW + 2;
   localparam int MAGW = FW + 1;
   localparam int BIAS = (1 << (EW - 1)) - 1;
   localparam logic signed [DW-1:0] D_OFFS  = DW'(FRAC - MW - BIAS);
   localparam logic signed [DW-1:0] D_LMAX  = DW'(FW - 2 - MW);
   localparam logic signed [DW-1:0] D_RMIN  = DW'(-(MW + 2));
   localparam logic [MAGW-1:0]      HALF    = MAGW'(1) << (FW - 1);
   localparam logic [FW-1:0]        POS_MAX = {1'b0, {(FW-1){1'b1}}};
   localparam logic [FW-1:0]        NEG_MIN = {1'b1, {(FW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ALIGN, ROUND, FINAL, DONE} state_t;

   state_t               state_q, state_d;
   logic                 armed_q;
   logic                 sign_q;
   logic                 shiftLeft_q;
   logic                 isNan_q;
   logic                 isSat_q;
   logic                 nonZero_q;
   logic [DW-1:0]        shiftCnt_q;
   logic [MAGW-1:0]      mag_q;
   logic [FW-1:0]        fixed_q;
   logic                 ovf_q;
   logic                 udf_q;
   logic                 inv_q;
`ifdef FLT2FIX_ROUND_EN
   logic                 guard_q;
   logic                 sticky_q;
`endif

   logic                 inReady;
   logic                 outValid;
   logic                 accept;

   logic                 signIn;
   logic [EW-1:0]        expIn;
   logic [MW-1:0]        manIn;
   logic signed [DW-1:0] dIn;
   logic                 expZero;
   logic                 expOnes;
   logic                 manNz;
   logic                 nanIn;
   logic                 satIn;
   logic                 tinyIn;
   logic                 noShift;
   logic [DW-1:0]        nIn;
   logic [MAGW-1:0]      magIn;

   logic [FW-1:0]        fixedD;
   logic                 ovfD;
   logic                 udfD;
   logic                 invD;

   // Operand decode: unbiased shift distance and the special cases that skip alignment entirely.
   assign signIn  = bus.floatIn[EW+MW];
   assign expIn   = bus.floatIn[EW+MW-1:MW];
   assign manIn   = bus.floatIn[MW-1:0];
   assign dIn     = $signed({2'b00, expIn}) + D_OFFS;
   assign expZero = (expIn == '0);
   assign expOnes = &expIn;
   assign manNz   = |manIn;
   assign nanIn   = expOnes & manNz;
   assign satIn   = (expOnes & ~manNz) | (~expOnes & ~expZero & (dIn > D_LMAX));
   assign tinyIn  = ~expOnes & ~expZero & (dIn < D_RMIN);
   assign noShift = expZero | expOnes | satIn | tinyIn;
   assign nIn     = noShift ? '0 : (dIn[DW-1] ? $unsigned(-dIn) : $unsigned(dIn));
   assign magIn   = noShift ? '0 : {{(MAGW-MW-1){1'b0}}, 1'b1, manIn};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (nIn != '0) ? ALIGN : ROUND;
         ALIGN:   if (shiftCnt_q == DW'(1)) state_d = ROUND;
         ROUND:   state_d = FINAL;
         FINAL:   state_d = DONE;
         DONE:    if (bus.outReady) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // armed_q keeps IN_READY low through reset and for the first edge after release.
   always_comb begin
      inReady  = armed_q && (state_q == IDLE);
      outValid = (state_q == DONE);
      accept   = bus.inValid && inReady;
   end

   assign bus.inReady  = inReady;
   assign bus.outValid = outValid;
   assign bus.fixedOut = fixed_q;
   assign bus.ovf      = ovf_q;
   assign bus.udf      = udf_q;
   assign bus.inv      = inv_q;

   // Sign application and saturation; exactly -2^(FW-1) stays representable.
   always_comb begin
      fixedD = '0;
      ovfD   = 1'b0;
      udfD   = 1'b0;
      invD   = 1'b0;
      if (isNan_q) begin
         invD = 1'b1;
      end else if (isSat_q || (!sign_q && (mag_q >= HALF)) || (sign_q && (mag_q > HALF))) begin
         ovfD   = 1'b1;
         fixedD = sign_q ? NEG_MIN : POS_MAX;
      end else begin
         fixedD = sign_q ? (FW'(0) - mag_q[FW-1:0]) : mag_q[FW-1:0];
         udfD   = nonZero_q && (mag_q == '0);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         armed_q     <= 1'b0;
         sign_q      <= 1'b0;
         shiftLeft_q <= 1'b0;
         isNan_q     <= 1'b0;
         isSat_q     <= 1'b0;
         nonZero_q   <= 1'b0;
         shiftCnt_q  <= '0;
         mag_q       <= '0;
         fixed_q     <= '0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         inv_q       <= 1'b0;
`ifdef FLT2FIX_ROUND_EN
         guard_q     <= 1'b0;
         sticky_q    <= 1'b0;
`endif
      end else begin
         armed_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  sign_q      <= signIn;
                  shiftLeft_q <= ~dIn[DW-1];
                  isNan_q     <= nanIn;
                  isSat_q     <= satIn;
                  nonZero_q   <= ~expZero | manNz;
                  shiftCnt_q  <= nIn;
                  mag_q       <= magIn;
`ifdef FLT2FIX_ROUND_EN
                  guard_q     <= 1'b0;
                  sticky_q    <= tinyIn;
`endif
               end
            end
            ALIGN: begin
               shiftCnt_q <= shiftCnt_q - DW'(1);
               if (shiftLeft_q) begin
                  mag_q <= mag_q << 1;
               end else begin
                  mag_q <= mag_q >> 1;
`ifdef FLT2FIX_ROUND_EN
                  guard_q  <= mag_q[0];
                  sticky_q <= sticky_q | guard_q;
`endif
               end
            end
            ROUND: begin
`ifdef FLT2FIX_ROUND_EN
               if (guard_q && (sticky_q || mag_q[0])) begin
                  mag_q <= mag_q + MAGW'(1);
               end
`endif
            end
            FINAL: begin
               fixed_q <= fixedD;
               ovf_q   <= ovfD;
               udf_q   <= udfD;
               inv_q   <= invD;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_flt2fix_seq_conv.sv
// Directed bench for flt2fix_seq_conv: hand-computed vectors, latency, backpressure and mid-flight reset.
module tb_flt2fix_seq_conv;
   localparam logic [2:0] F_NONE = 3'b000;
   localparam logic [2:0] F_OVF  = 3'b100;
   localparam logic [2:0] F_UDF  = 3'b010;
   localparam logic [2:0] F_INV  = 3'b001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   testsRun = 0;
   int   testsFailed = 0;
   int   lat;

   flt2fix_seq_conv_if bus ();

   flt2fix_seq_conv dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic sendOperand(input string tag, input logic [31:0] f);
      int waited = 0;
      while (!bus.inReady && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      checkOutput({tag, ".ready"}, {31'b0, bus.inReady}, 32'd1);
      bus.inValid = 1'b1;
      bus.floatIn = f;
      @(posedge clk); #1;
      bus.inValid = 1'b0;
      bus.floatIn = $urandom();
   endtask

   // Counts edges after the accept edge until OUT_VALID is seen, bounded.
   task automatic waitResult(output int cycles);
      cycles = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         cycles++;
         if (bus.outValid) break;
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [31:0] f, input logic [31:0] expFixed,
                                input logic [2:0] expFlags, input int expLat);
      int cycles;
      sendOperand(tag, f);
      waitResult(cycles);
      checkOutput({tag, ".lat"}, cycles, expLat);
      checkOutput({tag, ".fixed"}, bus.fixedOut, expFixed);
      checkOutput({tag, ".flags"}, {29'b0, bus.ovf, bus.udf, bus.inv}, {29'b0, expFlags});
      bus.outReady = 1'b1;
      @(posedge clk); #1;
      bus.outReady = 1'b0;
      checkOutput({tag, ".drop"}, {31'b0, bus.outValid}, 32'd0);
   endtask

   initial begin
      bus.inValid  = 1'b0;
      bus.outReady = 1'b0;
      bus.floatIn  = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst.inReady", {31'b0, bus.inReady}, 32'd0);
      checkOutput("rst.outValid", {31'b0, bus.outValid}, 32'd0);
      checkOutput("rst.fixed", bus.fixedOut, 32'd0);
      checkOutput("rst.flags", {29'b0, bus.ovf, bus.udf, bus.inv}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst.readyAfter", {31'b0, bus.inReady}, 32'd1);

      applyStimulus("one",      32'h3F800000, 32'h00010000, F_NONE, 9);
      applyStimulus("neg2p5",   32'hC0200000, 32'hFFFD8000, F_NONE, 8);
      applyStimulus("half",     32'h3F000000, 32'h00008000, F_NONE, 10);
      applyStimulus("big",      32'h471C4000, 32'h7FFFFFFF, F_OVF,  2);
      applyStimulus("maxLeft",  32'h46FFFFFF, 32'h7FFFFF80, F_NONE, 9);
      applyStimulus("minLeft",  32'hC6FFFFFF, 32'h80000080, F_NONE, 9);
      applyStimulus("overBy1",  32'h47000000, 32'h7FFFFFFF, F_OVF,  2);
      applyStimulus("negInf",   32'hFF800000, 32'h80000000, F_OVF,  2);
      applyStimulus("posInf",   32'h7F800000, 32'h7FFFFFFF, F_OVF,  2);
      applyStimulus("nan",      32'h7FC00000, 32'h00000000, F_INV,  2);
      applyStimulus("zero",     32'h00000000, 32'h00000000, F_NONE, 2);
      applyStimulus("negZero",  32'h80000000, 32'h00000000, F_NONE, 2);
      applyStimulus("denorm",   32'h00000001, 32'h00000000, F_UDF,  2);
      applyStimulus("tiny",     32'h30000000, 32'h00000000, F_UDF,  2);
      applyStimulus("tieEven",  32'h37000000, 32'h00000000, F_UDF,  26);
`ifdef FLT2FIX_ROUND_EN
      applyStimulus("rnd1p5",   32'h37C00000, 32'h00000002, F_NONE, 25);
      applyStimulus("rndN1p5",  32'hB7C00000, 32'hFFFFFFFE, F_NONE, 25);
      applyStimulus("rndUp",    32'h37400000, 32'h00000001, F_NONE, 26);
      applyStimulus("rndOdd",   32'h3F8000C0, 32'h00010002, F_NONE, 9);
`else
      applyStimulus("trc1p5",   32'h37C00000, 32'h00000001, F_NONE, 25);
      applyStimulus("trcN1p5",  32'hB7C00000, 32'hFFFFFFFF, F_NONE, 25);
      applyStimulus("trcDown",  32'h37400000, 32'h00000000, F_UDF,  26);
      applyStimulus("trcOdd",   32'h3F8000C0, 32'h00010001, F_NONE, 9);
`endif

      // Backpressure: result held, a competing operand is refused until the handshake.
      sendOperand("bp", 32'h3F800000);
      waitResult(lat);
      checkOutput("bp.lat", lat, 9);
      bus.inValid = 1'b1;
      bus.floatIn = 32'h40000000;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checkOutput("bp.holdFixed", bus.fixedOut, 32'h00010000);
         checkOutput("bp.holdValid", {31'b0, bus.outValid}, 32'd1);
         checkOutput("bp.holdReady", {31'b0, bus.inReady}, 32'd0);
      end
      bus.outReady = 1'b1;
      @(posedge clk); #1;
      bus.outReady = 1'b0;
      checkOutput("bp.dropValid", {31'b0, bus.outValid}, 32'd0);
      checkOutput("bp.readyIdle", {31'b0, bus.inReady}, 32'd1);
      @(posedge clk); #1;
      bus.inValid = 1'b0;
      bus.floatIn = $urandom();
      checkOutput("bp.accepted", {31'b0, bus.inReady}, 32'd0);
      waitResult(lat);
      checkOutput("bp.lat2", lat, 8);
      checkOutput("bp.fixed2", bus.fixedOut, 32'h00020000);
      bus.outReady = 1'b1;
      @(posedge clk); #1;
      bus.outReady = 1'b0;

      // Reset during ALIGN discards the operand and clears the held result.
      sendOperand("midRst", 32'h3F800000);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      checkOutput("midRst.outValid", {31'b0, bus.outValid}, 32'd0);
      checkOutput("midRst.fixed", bus.fixedOut, 32'd0);
      checkOutput("midRst.inReady", {31'b0, bus.inReady}, 32'd0);
      checkOutput("midRst.flags", {29'b0, bus.ovf, bus.udf, bus.inv}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("midRst.readyBack", {31'b0, bus.inReady}, 32'd1);
      checkOutput("midRst.noValid", {31'b0, bus.outValid}, 32'd0);
      applyStimulus("afterRst", 32'hC0200000, 32'hFFFD8000, F_NONE, 8);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", testsRun);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/flt2fix_seq_conv.md
# flt2fix_seq_conv

Parametrised, handshaked IEEE-754-style float-to-signed-fixed converter. Successor to the single-precision float-to-fixed datapath. Adds:
- generic exponent, mantissa and output widths;
- a valid/ready stream interface;
- an iterative one-bit-per-cycle aligner driven by an FSM;
- rounding, saturation, and special-value flags.

It sits between the float operand registers and the fixed-point arithmetic pipeline.

## Interface
- EW, 8, exponent width; bias = 2^(EW-1)-1
- MW, 23, stored mantissa width (hidden bit implied)
- FW, 32, output width, signed two's complement
- FRAC, 16, fractional bits of output
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- IN_VALID  in  1  FLOAT is valid
- IN_READY  out  1  block can accept an operand
- FLOAT  in  1+EW+MW  {sign, exponent, mantissa}
- OUT_VALID  out  1  FIXED and flags are valid
- OUT_READY  in  1  consumer accepts the result
- FIXED  out  FW  result
- OVF  out  1  result saturated (overflow or ±Inf)
- UDF  out  1  non-zero finite input produced 0
- INV  out  1  NaN input; FIXED = 0

## Operation
- Accept on the rising edge where IN_VALID & IN_READY. At that edge, register sign, exponent, {1,M} and shift distance d = E - bias + FRAC - MW (signed, EW+2 bits).
- IN_READY = 1 only in IDLE.
- Special cases are decoded at acceptance and set n = 0 (no ALIGN cycles):
  - E = 0 (zero or denormal): flushed to 0; UDF = 1 if M != 0.
  - E = all-ones, M != 0 (NaN): FIXED = 0, INV = 1.
  - E = all-ones, M = 0 (±Inf): saturate, OVF = 1.
  - d > FW-2-MW: saturate, OVF = 1.
  - d < -(MW+2): magnitude = 0, sticky = 1.
- Otherwise n = |d|. For d ≥ 0, shift left. For d < 0, shift right and track guard and sticky bits.
- FSM:
  - IDLE -> ALIGN on accept if n > 0, else -> ROUND.
  - ALIGN: shift one bit per cycle and decrement the counter; at counter = 1, go -> ROUND.
  - ROUND: apply rounding to the magnitude -> FINAL.
  - FINAL: apply the sign, check saturation, register outputs, assert OUT_VALID -> DONE.
  - DONE: hold; on OUT_READY -> IDLE.
- Saturation:
  - Positive: magnitude ≥ 2^(FW-1) -> 2^(FW-1)-1.
  - Negative: magnitude > 2^(FW-1) -> -2^(FW-1). Exactly -2^(FW-1) is representable and sets no OVF.
  - A rounding carry can cause overflow; this is also detected in FINAL.
- Negative results are the two's complement of the rounded magnitude. The sign of a zero result is discarded.
- UDF = 1 when a non-zero finite input yields magnitude 0 after rounding.

## Timing
- Reset: IN_READY = 0 while RST_N is low, then 1 in IDLE. OUT_VALID = 0, FIXED = 0, OVF/UDF/INV = 0, FSM = IDLE, counter = 0.
- With acceptance at edge k, OUT_VALID rises after edge k+n+2 and FIXED/flags are valid in the same cycle.
- Results are held stable while OUT_VALID & !OUT_READY. OUT_VALID falls after the handshake edge. The next operand can be accepted one cycle after that (IDLE).
- No overlap: one operand is in flight at a time.
- Reset asserted mid-operation aborts immediately; the in-flight operand is discarded and all outputs return to reset values.
- FLOAT is sampled only on the accept edge; later changes are ignored.

## Configuration
- FLT2FIX_ROUND_EN defined: round-to-nearest-even using guard and sticky bits.
- FLT2FIX_ROUND_EN undefined: truncate the magnitude toward zero. The ROUND state remains, so latency is unchanged.

## Test plan
All cases use default parameters and FLT2FIX_ROUND_EN defined unless stated.
- 0x3F800000 (1.0) -> FIXED = 0x00010000, flags 0, OUT_VALID 9 cycles after accept (n = 7).
- 0xC0200000 (-2.5) -> 0xFFFD8000, flags 0.
- 0x471C4000 (40000.0) -> 0x7FFFFFFF, OVF = 1, latency 2. 0xFF800000 (-Inf) -> 0x80000000, OVF = 1. 0x7FC00000 (NaN) -> 0, INV = 1.
- Rounding cases:
  - 0x37000000 (2^-17) -> 0, UDF = 1 (tie to even).
  - 0x37C00000 (1.5·2^-16) -> 0x00000002.
  - With FLT2FIX_ROUND_EN undefined, 0x37C00000 -> 0x00000001.
- Backpressure and reset:
  - Hold OUT_READY = 0 for 5 cycles -> FIXED stable, IN_READY = 0, and a second IN_VALID is not accepted.
  - Release OUT_READY -> the next operand is accepted one cycle later.
  - Pulse RST_N low during ALIGN -> outputs return to 0, then IN_READY returns to 1.
